// File: rtl/t10_guess_checker.sv
// rtl/t10_guess_checker.sv - guesser-side word game: latches the secret word, scores letter guesses, ends the round
module t10_guess_checker #(
  parameter int MAX_MISTAKES = 6,
  parameter int END_HOLD     = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        rec_ready,
  input  logic [39:0] temp_word,
  input  logic        guess_ready,
  input  logic [7:0]  guessLetter,
  output logic [39:0] display_word,
  output logic [2:0]  mistakes,
  output logic        busy,
  output logic        win,
  output logic        lose,
  output logic        gameEnd_host
);
  localparam logic [39:0] ALL_BLANK = {5{8'h5F}};
  localparam logic [2:0]  MAX_M     = 3'(MAX_MISTAKES);
  localparam logic [15:0] HOLD_LAST = 16'(END_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GUESS, S_CHECK, S_WIN, S_LOSE, S_END
  } state_t;

  state_t      state, state_next;
  logic [39:0] secret, secret_next, display_next, reveal;
  logic [2:0]  mistakes_next, miss_count;
  logic [25:0] used, used_next;
  logic [7:0]  guess, guess_next;
  logic [15:0] hold_cnt, hold_next;
  logic [4:0]  letter_idx;
  logic        is_letter, any_hit, abort;

  assign is_letter  = (guess >= 8'h41) && (guess <= 8'h5A);
  assign letter_idx = 5'(guess - 8'h41);
  assign miss_count = (mistakes < MAX_M) ? mistakes + 3'd1 : mistakes;
  assign abort      = !rec_ready && (state == S_LOAD || state == S_GUESS || state == S_CHECK);

  // Blank secret bytes already read 0x5F on the display, so a fully revealed word equals the secret.
  always_comb begin
    reveal  = display_word;
    any_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (secret[8*i +: 8] == guess) begin
        reveal[8*i +: 8] = secret[8*i +: 8];
        any_hit          = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    secret_next   = secret;
    display_next  = display_word;
    mistakes_next = mistakes;
    used_next     = used;
    guess_next    = guess;
    hold_next     = hold_cnt;
    busy          = (state != S_GUESS);
    win           = (state == S_WIN);
    lose          = (state == S_LOSE);
    gameEnd_host  = (state == S_END);

    if (abort) begin
      state_next    = S_IDLE;
      display_next  = ALL_BLANK;
      mistakes_next = 3'd0;
      used_next     = 26'd0;
    end else begin
      case (state)
        S_IDLE: if (rec_ready) state_next = S_LOAD;
        S_LOAD: begin
          secret_next   = temp_word;
          display_next  = ALL_BLANK;
          mistakes_next = 3'd0;
          used_next     = 26'd0;
          hold_next     = 16'd0;
          state_next    = (temp_word == ALL_BLANK) ? S_WIN : S_GUESS;
        end
        S_GUESS: begin
          if (guess_ready) begin
            guess_next = guessLetter;
            state_next = S_CHECK;
          end
        end
        S_CHECK: begin
          state_next = S_GUESS;
          hold_next  = 16'd0;
          if (is_letter && !used[letter_idx]) begin
            used_next[letter_idx] = 1'b1;
            if (any_hit) begin
              display_next = reveal;
              if (reveal == secret) state_next = S_WIN;
            end else begin
              mistakes_next = miss_count;
              if (miss_count == MAX_M) begin
                state_next   = S_LOSE;
                display_next = secret;
              end
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (hold_cnt == HOLD_LAST) state_next = S_END;
          else hold_next = hold_cnt + 16'd1;
        end
        S_END: begin
          state_next    = S_IDLE;
          display_next  = ALL_BLANK;
          mistakes_next = 3'd0;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= S_IDLE;
      secret       <= 40'd0;
      display_word <= ALL_BLANK;
      mistakes     <= 3'd0;
      used         <= 26'd0;
      guess        <= 8'd0;
      hold_cnt     <= 16'd0;
    end else begin
      state        <= state_next;
      secret       <= secret_next;
      display_word <= display_next;
      mistakes     <= mistakes_next;
      used         <= used_next;
      guess        <= guess_next;
      hold_cnt     <= hold_next;
    end
  end
endmodule

// File: tb/tb_t10_guess_checker.sv
// tb/tb_t10_guess_checker.sv - self-checking bench for t10_guess_checker against a letter-game model
module tb_t10_guess_checker;
  localparam int MAX_MISTAKES = 6;
  localparam int END_HOLD     = 8;
  localparam logic [39:0] ALL_BLANK = {5{8'h5F}};
  localparam logic [39:0] APPLE     = 40'h41_50_50_4C_45;

  logic        clk = 1'b0;
  logic        nRst, rec_ready, guess_ready;
  logic [39:0] temp_word;
  logic [7:0]  guessLetter;
  logic [39:0] display_word;
  logic [2:0]  mistakes;
  logic        busy, win, lose, gameEnd_host;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  t10_guess_checker #(.MAX_MISTAKES(MAX_MISTAKES), .END_HOLD(END_HOLD)) dut (
    .clk(clk), .nRst(nRst), .rec_ready(rec_ready), .temp_word(temp_word),
    .guess_ready(guess_ready), .guessLetter(guessLetter), .display_word(display_word),
    .mistakes(mistakes), .busy(busy), .win(win), .lose(lose), .gameEnd_host(gameEnd_host)
  );

  // Game model: letters of the word in reading order, which are shown, which letters were tried.
  logic [7:0] m_secret [5];
  bit         m_shown  [5];
  bit         m_used   [26];
  int         m_miss;

  function automatic void model_load(input logic [39:0] w);
    for (int k = 0; k < 5; k++) begin
      m_secret[k] = w[39-8*k -: 8];
      m_shown[k]  = (m_secret[k] == 8'h5F);
    end
    for (int k = 0; k < 26; k++) m_used[k] = 1'b0;
    m_miss = 0;
  endfunction

  function automatic void model_guess(input logic [7:0] l);
    int  idx;
    bit  hit;
    if (l < 8'h41 || l > 8'h5A) return;
    idx = int'(l) - 65;
    if (m_used[idx]) return;
    m_used[idx] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 5; k++)
      if (m_secret[k] == l) begin
        m_shown[k] = 1'b1;
        hit = 1'b1;
      end
    if (!hit && m_miss < MAX_MISTAKES) m_miss++;
  endfunction

  function automatic bit model_won();
    for (int k = 0; k < 5; k++) if (!m_shown[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_lost();
    return m_miss >= MAX_MISTAKES;
  endfunction

  function automatic logic [39:0] model_display();
    logic [39:0] d = 40'd0;
    for (int k = 0; k < 5; k++)
      d = {d[31:0], (m_shown[k] || model_lost()) ? m_secret[k] : 8'h5F};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [39:0] w);
    temp_word = w;
    rec_ready = 1'b1;
    tick();
    tick();
    model_load(w);
  endtask

  task automatic do_guess(input logic [7:0] l);
    guessLetter = l;
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    tick();
    model_guess(l);
  endtask

  task automatic finish_round(input string name);
    int win_cycles = 0, lose_cycles = 0, pulses = 0, n = 0, held;
    bit exp_win = model_won();
    while (!gameEnd_host && n < 100) begin
      if (win) win_cycles++;
      if (lose) lose_cycles++;
      tick();
      n++;
    end
    checks++;
    if (gameEnd_host !== 1'b1) begin
      errors++;
      $display("FAIL %s end_pulse_timeout: gameEnd_host=%b after %0d cycles, required 1", name, gameEnd_host, n);
    end
    held = exp_win ? win_cycles : lose_cycles;
    checks++;
    if (held !== END_HOLD || (exp_win ? lose_cycles : win_cycles) !== 0) begin
      errors++;
      $display("FAIL %s hold: win_cycles=%0d lose_cycles=%0d, required %0d on %s", name, win_cycles,
               lose_cycles, END_HOLD, exp_win ? "win" : "lose");
    end
    checks++;
    if (win !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL %s end_flags: win=%b lose=%b, required 0 0", name, win, lose);
    end
    rec_ready = 1'b0;
    pulses = gameEnd_host ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gameEnd_host) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d, required 1", name, pulses);
    end
    checks++;
    if (display_word !== ALL_BLANK || mistakes !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after_end: display=%h mistakes=%0d busy=%b, required %h 0 1", name,
               display_word, mistakes, busy, ALL_BLANK);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (display_word !== ALL_BLANK || mistakes !== 3'd0 || busy !== 1'b1 || win !== 1'b0 ||
        lose !== 1'b0 || gameEnd_host !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: display=%h mistakes=%0d busy=%b win=%b lose=%b end=%b", display_word,
               mistakes, busy, win, lose, gameEnd_host);
    end
    nRst = 1'b1;
    tick();
    start_round(APPLE);
    do_guess("B");
    do_guess("A");
    checks++;
    if (mistakes !== 3'd1 || display_word !== 40'h41_5F_5F_5F_5F) begin
      errors++;
      $display("FAIL reset_pregame: mistakes=%0d display=%h, required 1 415f5f5f5f", mistakes, display_word);
    end
    #2 nRst = 1'b0;
    #1;
    checks++;
    if (display_word !== ALL_BLANK || mistakes !== 3'd0 || busy !== 1'b1 || gameEnd_host !== 1'b0) begin
      errors++;
      $display("FAIL reset_midgame: display=%h mistakes=%0d busy=%b end=%b, required %h 0 1 0", display_word,
               mistakes, busy, gameEnd_host, ALL_BLANK);
    end
    rec_ready = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_win();
    start_round(APPLE);
    checks++;
    if (busy !== 1'b0 || display_word !== ALL_BLANK) begin
      errors++;
      $display("FAIL win_loaded: busy=%b display=%h, required 0 %h", busy, display_word, ALL_BLANK);
    end
    do_guess("A");
    do_guess("P");
    checks++;
    if (display_word !== 40'h41_50_50_5F_5F || display_word !== model_display()) begin
      errors++;
      $display("FAIL win_double_reveal: got %h, required 415050 5f5f", display_word);
    end
    do_guess("L");
    guessLetter = "E";
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || win !== 1'b0 || display_word !== 40'h41_50_50_4C_5F) begin
      errors++;
      $display("FAIL win_latency_n1: busy=%b win=%b display=%h, required 1 0 4150504c5f", busy, win, display_word);
    end
    tick();
    model_guess("E");
    checks++;
    if (win !== 1'b1 || display_word !== APPLE || win !== model_won()) begin
      errors++;
      $display("FAIL win_latency_n2: win=%b display=%h, required 1 %h", win, display_word, APPLE);
    end
    finish_round("win");
  endtask

  task automatic test_loss();
    logic [47:0] seq = "BCDFGH";
    start_round(APPLE);
    for (int i = 0; i < 6; i++) begin
      do_guess(seq[47-8*i -: 8]);
      checks++;
      if (mistakes !== 3'(i + 1) || mistakes !== 3'(m_miss) || lose !== model_lost()) begin
        errors++;
        $display("FAIL loss_step%0d: mistakes=%0d lose=%b, required %0d %b", i, mistakes, lose, i + 1, model_lost());
      end
    end
    checks++;
    if (lose !== 1'b1 || display_word !== APPLE || display_word !== model_display()) begin
      errors++;
      $display("FAIL loss_reveal: lose=%b display=%h, required 1 %h", lose, display_word, APPLE);
    end
    finish_round("loss");
  endtask

  task automatic test_repeats();
    start_round(APPLE);
    do_guess("Z");
    do_guess("Z");
    checks++;
    if (mistakes !== 3'd1 || mistakes !== 3'(m_miss)) begin
      errors++;
      $display("FAIL repeat_miss: mistakes=%0d, required 1", mistakes);
    end
    do_guess(8'h33);
    checks++;
    if (mistakes !== 3'd1 || display_word !== ALL_BLANK || busy !== 1'b0) begin
      errors++;
      $display("FAIL non_letter: mistakes=%0d display=%h busy=%b, required 1 %h 0", mistakes, display_word, busy, ALL_BLANK);
    end
    do_guess("P");
    do_guess("P");
    checks++;
    if (display_word !== 40'h5F_50_50_5F_5F || mistakes !== 3'd1 || display_word !== model_display()) begin
      errors++;
      $display("FAIL repeat_hit: display=%h mistakes=%0d, required 5f50505f5f 1", display_word, mistakes);
    end
    rec_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_partial();
    start_round(40'h5F_43_41_54_5F);
    checks++;
    if (display_word !== ALL_BLANK || win !== 1'b0) begin
      errors++;
      $display("FAIL partial_load: display=%h win=%b, required %h 0", display_word, win, ALL_BLANK);
    end
    do_guess("C");
    do_guess("A");
    do_guess("T");
    checks++;
    if (win !== 1'b1 || display_word !== 40'h5F_43_41_54_5F || win !== model_won()) begin
      errors++;
      $display("FAIL partial_win: win=%b display=%h, required 1 5f4341545f", win, display_word);
    end
    finish_round("partial");
    start_round(ALL_BLANK);
    checks++;
    if (win !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL blank_win: win=%b busy=%b, required 1 1", win, busy);
    end
    finish_round("blank");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    start_round(APPLE);
    guessLetter = "A";
    guess_ready = 1'b1;
    tick();
    guessLetter = "P";
    tick();
    guess_ready = 1'b0;
    tick();
    model_guess("A");
    checks++;
    if (display_word !== 40'h41_5F_5F_5F_5F || mistakes !== 3'd0 || busy !== 1'b0 ||
        display_word !== model_display()) begin
      errors++;
      $display("FAIL b2b_dropped: display=%h mistakes=%0d busy=%b, required 415f5f5f5f 0 0", display_word, mistakes, busy);
    end
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gameEnd_host) pulses++;
    end
    checks++;
    if (display_word !== ALL_BLANK || mistakes !== 3'd0 || busy !== 1'b1 || pulses !== 0) begin
      errors++;
      $display("FAIL abort: display=%h mistakes=%0d busy=%b pulses=%0d, required %h 0 1 0", display_word,
               mistakes, busy, pulses, ALL_BLANK);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [39:0] w;
      int n = 0;
      for (int k = 0; k < 5; k++)
        w[8*k +: 8] = ($urandom_range(0, 6) == 0) ? 8'h5F : 8'(8'h41 + $urandom_range(0, 5));
      start_round(w);
      while (!model_won() && !model_lost() && n < 60) begin
        logic [7:0] l;
        l = ($urandom_range(0, 9) == 0) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'(8'h41 + $urandom_range(0, 7));
        do_guess(l);
        checks++;
        if (display_word !== model_display() || mistakes !== 3'(m_miss) || win !== model_won() ||
            lose !== model_lost()) begin
          errors++;
          $display("FAIL random r%0d g%0d: display=%h mistakes=%0d win=%b lose=%b, required %h %0d %b %b", r, n,
                   display_word, mistakes, win, lose, model_display(), m_miss, model_won(), model_lost());
        end
        n++;
      end
      if (model_won() || model_lost()) finish_round("random");
      else begin
        rec_ready = 1'b0;
        tick();
        tick();
      end
    end
  endtask

  initial begin
    nRst        = 1'b0;
    rec_ready   = 1'b0;
    guess_ready = 1'b0;
    temp_word   = 40'd0;
    guessLetter = 8'd0;
    #12;
    test_reset();
    test_win();
    test_loss();
    test_repeats();
    test_partial();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
